parity_fetch_design: RTL and testbench
======================================

// Module: parity_fetch_design
// PURPOSE
//  - Self-contained parity test subsystem.
//  - A 4-bit up counter addresses a 16-entry data/parity table.
//  - A checker recomputes parity on the fetched byte and flags agreement with the stored bit.
//  - Top-level wrapper of the counter -> fetch -> check chain; drives a monitor/scoreboard.
// PARAMETERS
//  - CNT_W   4  counter / table address width (fixed; table has 2**CNT_W = 16 entries)
//  - DATA_W  8  fetched data width (fixed)
// PORTS
//  - clk       in   1  single clock; all state updates on rising edge
//  - rst       in   1  reset, synchronous, active-low
//  - match     out  1  1 = recomputed parity equals s_parity
//  - Q         out  4  current counter value / table address
//  - s_data    out  8  table data at address Q
//  - s_parity  out  1  stored parity bit at address Q
// BEHAVIOUR
//  - One clock, clk. Reset rst is synchronous and active-low.
//  - Counter:
//    - On a clk rising edge with rst==0: Q <= 4'd0.
//    - Otherwise: Q <= Q+1, modulo 16 (4'hF -> 4'h0, no flag).
//    - Functionally a binary up counter; every bit is clocked by clk. No derived clocks, despite the "ripple" name.
//  - Fetch: combinational from Q, zero latency.
//    - s_data = {4'hA, Q}
//    - s_parity = ^s_data (even parity: total 1s in {s_data, s_parity} is even), XOR err(Q)
//    - err(Q) = 1 only when ERR_INJECT_EN is defined and Q is 4'd5 or 4'd12; otherwise 0.
//  - Check: combinational, match = ~(^s_data ^ s_parity).
//  - Latency: s_data, s_parity and match are valid in the same cycle Q changes. Only Q is registered.
//  - Reset values (cycle after rst sampled low): Q=0, s_data=8'hA0, s_parity=0, match=1.
//  - Reset mid-count: the next edge forces Q=0 regardless of value. Outputs follow combinationally.
//  - Releasing rst: Q=0 holds for that edge's result, then increments on each following edge.
//  - Before the first reset edge, Q is X. No power-on value is guaranteed.
//  - No X propagation from s_data/s_parity once Q is known.
// CONFIGURATION
//  - Macro ERR_INJECT_EN:
//    - Defined: table entries 5 and 12 carry inverted parity. match=0 at Q=5 and Q=12, 1 elsewhere.
//    - Undefined: every entry has correct even parity; match is constantly 1 after reset.
//  - No other build-time options.
// TESTING
//  - rst=0 for 3 edges -> Q=0, s_data=8'hA0, s_parity=0, match=1.
//  - Release rst, count 3 edges -> Q=3, s_data=8'hA3, s_parity=0, match=1.
//    At Q=7: s_data=8'hA7, s_parity=1, match=1.
//  - ERR_INJECT_EN defined:
//    - Q=5 -> s_data=8'hA5, s_parity=1, match=0.
//    - Q=12 -> s_data=8'hAC, s_parity=1, match=0.
//    - Q=6 and Q=13 -> match=1.
//  - ERR_INJECT_EN undefined: run 32 edges -> match=1 every cycle; s_parity==^s_data every cycle.
//  - Wrap: Q=15 (s_data=8'hAF, s_parity=0) -> next edge Q=0, s_data=8'hA0.
//  - Reset mid-count: assert rst=0 at Q=9 -> next edge Q=0. Release -> Q=1 after one further edge.

Source files
------------

// File: rtl/parity_fetch_design.sv
// Counter -> table fetch -> parity check chain. A 4-bit counter addresses a 16-entry data/parity table.
// Build option ERR_INJECT_EN: entries 5 and 12 store inverted parity so the checker reports a mismatch there.
module parity_fetch_design (
  input  logic       clk,
  input  logic       rst,
  output logic       match,
  output logic [3:0] Q,
  output logic [7:0] s_data,
  output logic       s_parity
);

  localparam int CNT_W   = 4;
  localparam int DATA_W  = 8;
  localparam int ENTRIES = 2 ** CNT_W;
  localparam logic [DATA_W-CNT_W-1:0] DATA_TAG = 4'hA;

  logic [CNT_W-1:0]  q_q, q_d;
  logic [DATA_W-1:0] data_tbl   [ENTRIES];
  logic              parity_tbl [ENTRIES];
  logic [ENTRIES-1:0] err_mask;

`ifdef ERR_INJECT_EN
  assign err_mask = 16'b0001_0000_0010_0000;  // entries 12 and 5
`else
  assign err_mask = '0;
`endif

  always_comb begin
    q_d = q_q + 1'b1;
    if (!rst) q_d = '0;
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  // Table contents are fixed: tag nibble over the address, with even parity unless flagged bad.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      data_tbl[i]   = {DATA_TAG, i[CNT_W-1:0]};
      parity_tbl[i] = (^data_tbl[i]) ^ err_mask[i];
    end
  end

  assign Q        = q_q;
  assign s_data   = data_tbl[q_q];
  assign s_parity = parity_tbl[q_q];
  assign match    = ~((^s_data) ^ s_parity);

endmodule

// File: tb/tb_parity_fetch_design.sv
// Bench for parity_fetch_design: directed sequences plus random reset/run stimulus,
// scored against a queue of expected outputs from a behavioural table model.
module tb_parity_fetch_design;

  logic       clk;
  logic       rst;
  logic       match;
  logic [3:0] Q;
  logic [7:0] s_data;
  logic       s_parity;

  int n_checks = 0;
  int n_pass   = 0;
  int mdl_q    = 0;
  logic [13:0] exp_q[$];

`ifdef ERR_INJECT_EN
  localparam logic ERR_BUILD = 1'b1;
`else
  localparam logic ERR_BUILD = 1'b0;
`endif

  parity_fetch_design dut (
    .clk      (clk),
    .rst      (rst),
    .match    (match),
    .Q        (Q),
    .s_data   (s_data),
    .s_parity (s_parity)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Expected {Q, data, parity, match} for table address q, from the table's stated rules.
  function automatic logic [13:0] model_out(input int q);
    int   ones;
    logic bad;
    logic par;
    logic [7:0] data;
    data = 8'(8'hA0 + q);
    ones = $countones(data);
    bad  = ERR_BUILD && (q == 5 || q == 12);
    par  = ((ones % 2) == 1) ^ bad;
    return {4'(q), data, par, !bad};
  endfunction

  // driver: apply rst for one edge, advance the model, score the result #1 later
  task automatic step(input logic r);
    logic [13:0] e;
    rst = r;
    @(posedge clk);
    mdl_q = r ? (mdl_q + 1) % 16 : 0;
    exp_q.push_back(model_out(mdl_q));
    #1;
    e = exp_q.pop_front();
    check_eq("sb_q",      Q,        e[13:10]);
    check_eq("sb_data",   s_data,   e[9:2]);
    check_eq("sb_parity", s_parity, e[1]);
    check_eq("sb_match",  match,    e[0]);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    @(negedge clk);

    repeat (3) step(1'b0);
    check_eq("rst_q", Q, 4'd0);
    check_eq("rst_data", s_data, 8'hA0);
    check_eq("rst_parity", s_parity, 1'b0);
    check_eq("rst_match", match, 1'b1);

    repeat (3) step(1'b1);
    check_eq("cnt3_q", Q, 4'd3);
    check_eq("cnt3_data", s_data, 8'hA3);
    check_eq("cnt3_parity", s_parity, 1'b0);

    repeat (4) step(1'b1);
    check_eq("q7_data", s_data, 8'hA7);
    check_eq("q7_parity", s_parity, 1'b1);
    check_eq("q7_match", match, 1'b1);

    repeat (2) step(1'b1);
    check_eq("q9_q", Q, 4'd9);
    step(1'b0);
    check_eq("midrst_q", Q, 4'd0);
    step(1'b1);
    check_eq("release_q", Q, 4'd1);

    // 32-edge sweep: two full wraps, spot-checking the error-injection entries
    for (int i = 0; i < 32; i++) begin
      step(1'b1);
      if (mdl_q == 5) begin
        check_eq("q5_parity", s_parity, ERR_BUILD);
        check_eq("q5_match", match, !ERR_BUILD);
      end
      if (mdl_q == 12) begin
        check_eq("q12_data", s_data, 8'hAC);
        check_eq("q12_match", match, !ERR_BUILD);
      end
      if (mdl_q == 6 || mdl_q == 13) check_eq("q6_13_match", match, 1'b1);
      if (mdl_q == 15) begin
        check_eq("q15_data", s_data, 8'hAF);
        check_eq("q15_parity", s_parity, 1'b0);
      end
      if (mdl_q == 0) check_eq("wrap_data", s_data, 8'hA0);
      check_eq("parity_rule", s_parity, (^s_data) ^ (ERR_BUILD && (mdl_q == 5 || mdl_q == 12)));
    end

    // random resets at random points in the count
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 9) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
